// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, runs the syn/ack/last handshake to instruction memory, hands words to decode.
// Latency: one edge from an acked request to f_o_ce; peak rate is one instruction every two cycles.
// Backpressure: f_i_stall holds the issued word and all outputs; no new request is raised until the word is consumed.
//
// Ports:
//   f_clk, f_rst                       clock (rising edge), asynchronous active-high reset
//   f_i_ce                             fetch enable
//   f_i_stall                          decode cannot accept the presented word
//   f_i_change_pc, f_i_alt_pc          one-cycle redirect pulse and its target (used verbatim)
//   f_o_syn, f_o_addr                  memory request and its address (address stable while syn=1)
//   f_i_ack, f_i_instr, f_i_last       memory response; instr/last qualified by ack
//   f_o_instr, f_o_pc, f_o_ce          word presented to decode, its PC, and its valid
//   f_o_done                           last instruction of the program has been consumed
//   f_o_err                            memory ack time-out, sticky until reset
module fetch_sequencer #(
  parameter int unsigned IWIDTH   = 32,
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned PC_STEP  = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                f_clk,
  input  logic                f_rst,
  input  logic                f_i_ce,
  input  logic                f_i_stall,
  input  logic                f_i_change_pc,
  input  logic [PC_WIDTH-1:0] f_i_alt_pc,
  output logic                f_o_syn,
  output logic [PC_WIDTH-1:0] f_o_addr,
  input  logic                f_i_ack,
  input  logic [IWIDTH-1:0]   f_i_instr,
  input  logic                f_i_last,
  output logic [IWIDTH-1:0]   f_o_instr,
  output logic [PC_WIDTH-1:0] f_o_pc,
  output logic                f_o_ce,
  output logic                f_o_done,
  output logic                f_o_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [PC_WIDTH-1:0] STEP   = PC_WIDTH'(PC_STEP);
  localparam logic [CW-1:0]       TO_MAX = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_ISSUE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] addr_q, addr_d;
  logic                syn_q, syn_d;
  logic [IWIDTH-1:0]   instr_q, instr_d;
  logic [PC_WIDTH-1:0] opc_q, opc_d;
  logic                ce_q, ce_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                last_q, last_d;
  // Set when a redirect arrives while a request is outstanding: the word
  // that eventually answers the stale request must be thrown away.
  logic                drop_q, drop_d;
  logic [CW-1:0]       tcnt_q, tcnt_d;
  logic [CW-1:0]       tcnt_inc;

  assign tcnt_inc = tcnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    syn_d   = syn_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    ce_d    = ce_q;
    done_d  = done_q;
    err_d   = err_q;
    last_d  = last_q;
    drop_d  = drop_q;
    // The time-out counter only lives inside REQ; every other path clears it.
    tcnt_d  = '0;

    case (state_q)
      S_IDLE: begin
        if (f_i_change_pc) begin
          pc_d = f_i_alt_pc;
        end else if (f_i_ce) begin
          state_d = S_REQ;
          syn_d   = 1'b1;
          addr_d  = pc_q;
        end
      end

      S_REQ: begin
        if (f_i_ack && f_i_change_pc) begin
          // Word answering this request is stale; re-request at the target.
          pc_d   = f_i_alt_pc;
          addr_d = f_i_alt_pc;
          drop_d = 1'b0;
        end else if (f_i_ack && drop_q) begin
          // pc already holds the redirect target; keep syn up and move the address.
          addr_d = pc_q;
          drop_d = 1'b0;
        end else if (f_i_ack) begin
          instr_d = f_i_instr;
          opc_d   = pc_q;
          ce_d    = 1'b1;
          syn_d   = 1'b0;
          pc_d    = pc_q + STEP;
          last_d  = f_i_last;
          state_d = S_ISSUE;
        end else begin
          if (f_i_change_pc) begin
            pc_d   = f_i_alt_pc;
            drop_d = 1'b1;
          end
          if (tcnt_inc == TO_MAX) begin
            state_d = S_ERR;
            syn_d   = 1'b0;
            err_d   = 1'b1;
            drop_d  = 1'b0;
          end else begin
            tcnt_d = tcnt_inc;
          end
        end
      end

      S_ISSUE: begin
        if (f_i_change_pc) begin
          // Flush the presented word regardless of stall.
          pc_d   = f_i_alt_pc;
          ce_d   = 1'b0;
          last_d = 1'b0;
          if (f_i_ce) begin
            state_d = S_REQ;
            syn_d   = 1'b1;
            addr_d  = f_i_alt_pc;
          end else begin
            state_d = S_IDLE;
          end
        end else if (!f_i_stall) begin
          ce_d = 1'b0;
          if (last_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            last_d  = 1'b0;
          end else if (f_i_ce) begin
            state_d = S_REQ;
            syn_d   = 1'b1;
            addr_d  = pc_q;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DONE: begin
        if (f_i_change_pc) begin
          pc_d   = f_i_alt_pc;
          done_d = 1'b0;
          if (f_i_ce) begin
            state_d = S_REQ;
            syn_d   = 1'b1;
            addr_d  = f_i_alt_pc;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_ERR: begin
        // Terminal until reset; redirects and acks have no effect.
      end

      default: begin
        state_d = S_IDLE;
        syn_d   = 1'b0;
        ce_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge f_clk or posedge f_rst) begin
    if (f_rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      syn_q   <= 1'b0;
      instr_q <= '0;
      opc_q   <= '0;
      ce_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      drop_q  <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      syn_q   <= syn_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      ce_q    <= ce_d;
      done_q  <= done_d;
      err_q   <= err_d;
      last_q  <= last_d;
      drop_q  <= drop_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign f_o_syn   = syn_q;
  assign f_o_addr  = addr_q;
  assign f_o_instr = instr_q;
  assign f_o_pc    = opc_q;
  assign f_o_ce    = ce_q;
  assign f_o_done  = done_q;
  assign f_o_err   = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: cycle table of inputs/expected outputs plus a scoreboard of issued words.
// Latency: each table row is one clock; outputs are sampled 1 time unit after the rising edge.
// Backpressure: stall, redirect, time-out and reset corners are driven from the table and short hand sequences.
module tb_fetch_sequencer;

  logic        f_clk = 1'b0;
  logic        f_rst = 1'b0;
  logic        f_i_ce = 1'b0;
  logic        f_i_stall = 1'b0;
  logic        f_i_change_pc = 1'b0;
  logic [31:0] f_i_alt_pc = '0;
  logic        f_o_syn;
  logic [31:0] f_o_addr;
  logic        f_i_ack = 1'b0;
  logic [31:0] f_i_instr = '0;
  logic        f_i_last = 1'b0;
  logic [31:0] f_o_instr;
  logic [31:0] f_o_pc;
  logic        f_o_ce;
  logic        f_o_done;
  logic        f_o_err;

  fetch_sequencer #(
    .IWIDTH(32), .PC_WIDTH(32), .PC_STEP(4), .RESET_PC(32'h0), .TIMEOUT(15)
  ) dut (
    .f_clk(f_clk), .f_rst(f_rst), .f_i_ce(f_i_ce), .f_i_stall(f_i_stall),
    .f_i_change_pc(f_i_change_pc), .f_i_alt_pc(f_i_alt_pc),
    .f_o_syn(f_o_syn), .f_o_addr(f_o_addr), .f_i_ack(f_i_ack),
    .f_i_instr(f_i_instr), .f_i_last(f_i_last), .f_o_instr(f_o_instr),
    .f_o_pc(f_o_pc), .f_o_ce(f_o_ce), .f_o_done(f_o_done), .f_o_err(f_o_err)
  );

  always #5 f_clk = ~f_clk;

  typedef struct {
    logic [31:0] ce, stall, chg, alt, ack, instr, last, keep, wpc;
    logic [31:0] e_syn, e_addr, e_ce, e_instr, e_pc, e_done, e_err;
  } vec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic prev_ce = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // keep=1 means this row's ack must reach decode as {instr, wpc}.
  task automatic add(input logic [31:0] ce, stall, chg, alt, ack, instr, last, keep, wpc,
                     input logic [31:0] e_syn, e_addr, e_ce, e_instr, e_pc, e_done, e_err);
    vec_t v;
    v.ce = ce; v.stall = stall; v.chg = chg; v.alt = alt; v.ack = ack;
    v.instr = instr; v.last = last; v.keep = keep; v.wpc = wpc;
    v.e_syn = e_syn; v.e_addr = e_addr; v.e_ce = e_ce; v.e_instr = e_instr;
    v.e_pc = e_pc; v.e_done = e_done; v.e_err = e_err;
    tbl.push_back(v);
  endtask

  // A rising f_o_ce marks a newly issued word; it must match the scoreboard head.
  task automatic monitor();
    exp_t e;
    if (f_o_ce && !prev_ce) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected: issued instr 0x%08h pc 0x%08h, expected no issue", f_o_instr, f_o_pc);
      end else begin
        e = sb.pop_front();
        check("sb_instr", f_o_instr, e.instr);
        check("sb_pc", f_o_pc, e.pc);
      end
    end
    prev_ce = f_o_ce;
  endtask

  task automatic tick();
    @(posedge f_clk);
    #1;
    monitor();
  endtask

  task automatic check_all(input string tag, input logic [31:0] syn, addr, ce, instr, pc, done, err);
    check({tag, "_syn"},   32'(f_o_syn),  syn);
    check({tag, "_addr"},  f_o_addr,      addr);
    check({tag, "_ce"},    32'(f_o_ce),   ce);
    check({tag, "_instr"}, f_o_instr,     instr);
    check({tag, "_pc"},    f_o_pc,        pc);
    check({tag, "_done"},  32'(f_o_done), done);
    check({tag, "_err"},   32'(f_o_err),  err);
  endtask

  task automatic run_rows(input int lo, input int hi);
    vec_t v;
    for (int i = lo; i <= hi; i++) begin
      v = tbl[i];
      f_i_ce        = v.ce[0];
      f_i_stall     = v.stall[0];
      f_i_change_pc = v.chg[0];
      f_i_alt_pc    = v.alt;
      f_i_ack       = v.ack[0];
      f_i_instr     = v.instr;
      f_i_last      = v.last[0];
      if (v.keep[0]) sb.push_back({v.instr, v.wpc});
      tick();
      check_all($sformatf("row%0d", i), v.e_syn, v.e_addr, v.e_ce, v.e_instr, v.e_pc, v.e_done, v.e_err);
    end
  endtask

  initial begin
    //   ce stl chg alt           ack instr          last keep wpc            | syn addr          ce instr          pc            dn er
    // two back-to-back fetches, syn and ce alternating
    add(1, 0, 0, 0,            0, 0,             0, 0, 0,            1, 0,            0, 0,            0,            0, 0); // 0
    add(1, 0, 0, 0,            1, 32'h20080005,  0, 1, 0,            0, 0,            1, 32'h20080005, 0,            0, 0); // 1
    add(1, 0, 0, 0,            0, 0,             0, 0, 0,            1, 4,            0, 32'h20080005, 0,            0, 0); // 2
    add(1, 0, 0, 0,            1, 32'h20090007,  0, 1, 4,            0, 4,            1, 32'h20090007, 4,            0, 0); // 3
    // stall three cycles; a stray ack with last in ISSUE is ignored
    add(1, 1, 0, 0,            0, 0,             0, 0, 0,            0, 4,            1, 32'h20090007, 4,            0, 0); // 4
    add(1, 1, 0, 0,            1, 32'hDEADBEEF,  1, 0, 0,            0, 4,            1, 32'h20090007, 4,            0, 0); // 5
    add(1, 1, 0, 0,            0, 0,             0, 0, 0,            0, 4,            1, 32'h20090007, 4,            0, 0); // 6
    add(1, 0, 0, 0,            0, 0,             0, 0, 0,            1, 8,            0, 32'h20090007, 4,            0, 0); // 7
    // last word at pc 8, then DONE holds with ce=1 and ignores ack
    add(1, 0, 0, 0,            1, 32'h00000013,  1, 1, 8,            0, 8,            1, 32'h00000013, 8,            0, 0); // 8
    add(1, 0, 0, 0,            0, 0,             0, 0, 0,            0, 8,            0, 32'h00000013, 8,            1, 0); // 9
    add(1, 0, 0, 0,            1, 32'h77,        0, 0, 0,            0, 8,            0, 32'h00000013, 8,            1, 0); // 10
    // leave DONE to 0xC, redirect to 0x40 mid-REQ, stale ack two cycles later
    add(1, 0, 1, 32'hC,        0, 0,             0, 0, 0,            1, 32'hC,        0, 32'h00000013, 8,            0, 0); // 11
    add(1, 0, 1, 32'h40,       0, 0,             0, 0, 0,            1, 32'hC,        0, 32'h00000013, 8,            0, 0); // 12
    add(1, 0, 0, 0,            0, 0,             0, 0, 0,            1, 32'hC,        0, 32'h00000013, 8,            0, 0); // 13
    add(1, 0, 0, 0,            1, 32'hBAD,       0, 0, 0,            1, 32'h40,       0, 32'h00000013, 8,            0, 0); // 14
    add(1, 0, 0, 0,            1, 32'h11,        0, 1, 32'h40,       0, 32'h40,       1, 32'h11,       32'h40,       0, 0); // 15
    // redirect flushes a stalled word, ce=0 goes to IDLE
    add(0, 1, 1, 32'h100,      0, 0,             0, 0, 0,            0, 32'h40,       0, 32'h11,       32'h40,       0, 0); // 16
    add(1, 0, 0, 0,            0, 0,             0, 0, 0,            1, 32'h100,      0, 32'h11,       32'h40,       0, 0); // 17
    // ack in the same cycle as a redirect is dropped
    add(1, 0, 1, 32'h200,      1, 32'h22,        0, 0, 0,            1, 32'h200,      0, 32'h11,       32'h40,       0, 0); // 18
    // ce drops during REQ: word still issued, then IDLE
    add(0, 0, 0, 0,            1, 32'h33,        0, 1, 32'h200,      0, 32'h200,      1, 32'h33,       32'h200,      0, 0); // 19
    add(0, 0, 0, 0,            0, 0,             0, 0, 0,            0, 32'h200,      0, 32'h33,       32'h200,      0, 0); // 20
    add(0, 0, 1, 32'h300,      0, 0,             0, 0, 0,            0, 32'h200,      0, 32'h33,       32'h200,      0, 0); // 21
    add(1, 0, 0, 0,            0, 0,             0, 0, 0,            1, 32'h300,      0, 32'h33,       32'h200,      0, 0); // 22
    // after reset: PC wrap-around through 0xFFFFFFFC
    add(1, 0, 0, 0,            0, 0,             0, 0, 0,            1, 0,            0, 0,            0,            0, 0); // 23
    add(1, 0, 0, 0,            1, 32'h44,        0, 1, 0,            0, 0,            1, 32'h44,       0,            0, 0); // 24
    add(1, 0, 1, 32'hFFFFFFFC, 0, 0,             0, 0, 0,            1, 32'hFFFFFFFC, 0, 32'h44,       0,            0, 0); // 25
    add(1, 0, 0, 0,            1, 32'h55,        0, 1, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 1, 32'h55,       32'hFFFFFFFC, 0, 0); // 26
    add(1, 0, 0, 0,            0, 0,             0, 0, 0,            1, 0,            0, 32'h55,       32'hFFFFFFFC, 0, 0); // 27
    add(1, 0, 0, 0,            1, 32'h66,        0, 1, 0,            0, 0,            1, 32'h66,       0,            0, 0); // 28
    add(1, 0, 0, 0,            0, 0,             0, 0, 0,            1, 4,            0, 32'h66,       0,            0, 0); // 29

    // reset state
    #1 f_rst = 1'b1;
    #1 check_all("reset", 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    f_rst = 1'b0;
    prev_ce = 1'b0;

    run_rows(0, 22);

    // time-out: REQ at 0x300 with no ack; error on the 15th unacked cycle
    f_i_ce = 1'b1; f_i_stall = 1'b0; f_i_change_pc = 1'b0; f_i_ack = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i < 15) begin
        check($sformatf("to_syn_%0d", i), 32'(f_o_syn), 1);
        check($sformatf("to_err_%0d", i), 32'(f_o_err), 0);
      end else begin
        check("to_fire_syn", 32'(f_o_syn), 0);
        check("to_fire_err", 32'(f_o_err), 1);
      end
    end
    check("to_addr", f_o_addr, 32'h300);

    // ERR ignores redirect and ack
    f_i_change_pc = 1'b1; f_i_alt_pc = 32'h500; f_i_ack = 1'b1; f_i_instr = 32'h99;
    tick();
    f_i_change_pc = 1'b0;
    tick();
    check_all("err_hold", 0, 32'h300, 0, 32'h33, 32'h200, 0, 1);

    // async reset clears the sticky error without a clock edge
    f_i_ack = 1'b0; f_i_ce = 1'b0;
    #2 f_rst = 1'b1;
    #1 check_all("err_rst", 0, 0, 0, 0, 0, 0, 0);
    prev_ce = 1'b0;
    tick();
    f_rst = 1'b0;

    run_rows(23, 29);

    // reset mid-REQ at addr 4: outputs drop at once, fetch restarts at 0
    #2 f_rst = 1'b1;
    #1 check_all("midreq_rst", 0, 0, 0, 0, 0, 0, 0);
    prev_ce = 1'b0;
    #1 f_rst = 1'b0;
    f_i_ce = 1'b1;
    tick();
    check("restart_syn", 32'(f_o_syn), 1);
    check("restart_addr", f_o_addr, 0);

    check("sb_empty", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
